reg64_axil_cmd_master: RTL and testbench
========================================

# reg64_axil_cmd_master

Hardware AXI4-Lite master that turns a simple valid/ready command stream into single-beat AXI4-Lite write or read transactions. It sits directly upstream of the reg64 AXI4-Lite slave register file and replaces the VIP master used in simulation, so on-chip logic can program and read back the four 32-bit registers. Each accepted command yields exactly one response, with one transaction outstanding at a time.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; only 32 supported
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with the timeout macro
- ACLK  in  1  single clock, all logic on rising edge
- ARESET  in  1  one clock; reset is synchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address, 4-byte aligned
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout
- rsp_timeout  out  1  response was produced by the watchdog
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready: standard AXI4-Lite write channels, master side
- m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite read channels, master side
- AWPROT/ARPROT are not ports; tie them to 3'b000 at the block-design level.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On handshake, register addr/data/strb/write and go to WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid rise together. Each drops independently on its own handshake, in any order or the same cycle. Go to WR_RESP once both have completed.
- WR_RESP: bready=1. On bvalid, capture bresp and go to RSP.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata/rresp and go to RSP.
- RSP: rsp_valid=1, and outputs stay stable until rsp_ready, then return to IDLE.
- All AXI outputs are registered. Address, data and strobe stay constant while their valid is high.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, all AXI valid/ready=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, state IDLE. cmd_ready rises in the first cycle after ARESET deasserts.
- Command accepted at edge N: AXI valids are high from cycle N+1.
- B or R handshake at edge M: rsp_valid is high from cycle M+1.
- Minimum command-to-command spacing with a zero-wait slave and rsp_ready held high: write 4 cycles, read 4 cycles.
- Reset mid-transaction: all valids drop at the next edge and the state returns to IDLE. The outstanding transaction is abandoned and the slave must share the reset.
- A slave asserting bvalid/rvalid before this block reaches the response state is handled by the normal AXI hold rule; nothing is lost.

## Configuration
- REG64_AXIL_TIMEOUT_EN defined:
  - A counter clears on entering WR_REQ or RD_REQ and increments every cycle until RSP.
  - When the count reaches TIMEOUT_CYCLES, the block deasserts all AXI valid/ready, enters RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
- Undefined: there is no counter, rsp_timeout is constant 0, and the block waits indefinitely.

## Structure
- Package reg64_axil_pkg holds:
  - the state enum;
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the default TIMEOUT_CYCLES.
- Sub-module reg64_axil_wdog contains the timeout counter (clear, enable, expired). It is instantiated only under the macro.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four back. Required: rsp_rdata matches and rsp_resp=0 every time.
- Slave asserts awready 3 cycles before wready, then the reverse. Required: exactly one AW and one W handshake each, and one response.
- rsp_ready held low 5 cycles. Required: rsp_valid and data stay stable, cmd_ready stays 0, then IDLE the cycle after the handshake.
- Write 0xAABBCCDD with wstrb=4'b0011 over 0x11223344 at 0x4. Required: read returns 0x1122CCDD.
- With the macro defined and TIMEOUT_CYCLES=16, arready is held at 0. Required: rsp_valid 17 cycles after acceptance, rsp_resp=2'b10, rsp_timeout=1, arvalid low.
- ARESET pulsed while in RD_RESP. Required: all outputs return to reset values next cycle, and a following read completes normally.

Source files
------------

// File: rtl/reg64_axil_pkg.sv
// Shared types and constants for the reg64 AXI4-Lite command master.
package reg64_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

  // True while an AXI transaction is outstanding on the bus.
  function automatic logic is_busy(state_t s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_REQ) || (s == ST_RD_RESP);
  endfunction

endpackage

// File: rtl/reg64_axil_wdog.sv
// Transaction watchdog: counts busy cycles and flags the cycle in which the
// count reaches LIMIT, so the owner can abort on the following edge.
module reg64_axil_wdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step while enabled.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/reg64_axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command stream.
// Optional watchdog abort enabled by defining REG64_AXIL_TIMEOUT_EN.
module reg64_axil_cmd_master
  import reg64_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("reg64_axil_cmd_master supports DATA_WIDTH=32 only");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("reg64_axil_cmd_master needs TIMEOUT_CYCLES >= 2");
  end

  state_t                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      write_q, write_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      rsp_timeout_q, rsp_timeout_d;

`ifdef REG64_AXIL_TIMEOUT_EN
  logic wdog_expired;

  reg64_axil_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk_i    (ACLK),
    .rst_i    (ARESET),
    .clear_i  (state_q == ST_IDLE),
    .en_i     (is_busy(state_q)),
    .expired_o(wdog_expired)
  );
`endif

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = ST_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W retire independently; advance once neither is pending.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          state_d       = ST_RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = write_q;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi_bresp;
          rsp_timeout_d = 1'b0;
        end
      end
      ST_RD_REQ: begin
        if (arvalid_q && m_axi_arready) begin
          state_d   = ST_RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (m_axi_rvalid && rready_q) begin
          state_d       = ST_RSP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = write_q;
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = m_axi_rresp;
          rsp_timeout_d = 1'b0;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef REG64_AXIL_TIMEOUT_EN
    // Watchdog overrides any bus progress in the same cycle.
    if (wdog_expired) begin
      state_d       = ST_RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_write_d   = write_q;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
    end
`endif

    // cmd_ready is registered from the next state so it is low during reset.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_reg64_axil_cmd_master.sv
// Scoreboard bench for reg64_axil_cmd_master against a small reg64-like slave.
// The timeout scenario runs only when REG64_AXIL_TIMEOUT_EN is defined.
module tb_reg64_axil_cmd_master;
  import reg64_axil_pkg::*;

  localparam int unsigned TMO = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  reg64_axil_cmd_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [31:0] mem [0:3];
  int unsigned aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  bit          ar_block = 1'b0;
  int unsigned aw_wait, w_wait, ar_wait, r_cnt;
  int unsigned aw_hs_cnt = 0, w_hs_cnt = 0;
  logic        aw_got, w_got, r_pend;
  logic [31:0] aw_lat, w_lat;
  logic [3:0]  ws_lat;

  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid && (w_wait >= w_dly);
  assign m_axi_arready = m_axi_arvalid && !ar_block && (ar_wait >= ar_dly);

  wire        hs_aw  = m_axi_awvalid && m_axi_awready;
  wire        hs_w   = m_axi_wvalid && m_axi_wready;
  wire        hs_ar  = m_axi_arvalid && m_axi_arready;
  wire [31:0] cur_aw = hs_aw ? m_axi_awaddr : aw_lat;
  wire [31:0] cur_wd = hs_w ? m_axi_wdata : w_lat;
  wire [3:0]  cur_ws = hs_w ? m_axi_wstrb : ws_lat;
  wire [1:0]  aw_idx = cur_aw[3:2];
  wire [1:0]  ar_idx = m_axi_araddr[3:2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
      m_axi_bresp <= RESP_OKAY; m_axi_rresp <= RESP_OKAY; m_axi_rdata <= '0;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (hs_aw) begin aw_lat <= m_axi_awaddr; aw_hs_cnt <= aw_hs_cnt + 1; end
      if (hs_w) begin w_lat <= m_axi_wdata; ws_lat <= m_axi_wstrb; w_hs_cnt <= w_hs_cnt + 1; end
      if ((aw_got || hs_aw) && (w_got || hs_w)) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        m_axi_bvalid <= 1'b1;
        if (cur_aw < 32'h10) begin
          mem[aw_idx] <= merge(mem[aw_idx], cur_wd, cur_ws);
          m_axi_bresp <= RESP_OKAY;
        end else begin
          m_axi_bresp <= RESP_DECERR;
        end
      end else begin
        if (hs_aw) aw_got <= 1'b1;
        if (hs_w)  w_got  <= 1'b1;
      end
      if (hs_ar) begin
        m_axi_rdata <= (m_axi_araddr < 32'h10) ? mem[ar_idx] : 32'h0;
        m_axi_rresp <= (m_axi_araddr < 32'h10) ? RESP_OKAY : RESP_DECERR;
        if (r_dly == 0) m_axi_rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= r_dly; end
      end else if (r_pend) begin
        if (r_cnt <= 1) begin m_axi_rvalid <= 1'b1; r_pend <= 1'b0; end
        r_cnt <= r_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int unsigned n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response handshake is checked against the oldest expectation.
  initial begin
    forever begin
      @(negedge ACLK);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got response rdata 0x%08h with empty scoreboard", rsp_rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_write",   32'(rsp_write),   32'(e.write));
          chk("rsp_rdata",   rsp_rdata,        e.rdata);
          chk("rsp_resp",    32'(rsp_resp),    32'(e.resp));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit push, input logic [31:0] erd,
                      input logic [1:0] eresp, input bit etmo, output int unsigned acc);
    bit ok;
    if (push) begin
      exp_t e;
      e.write = wr;
      e.rdata = wr ? 32'h0 : erd;
      e.resp  = eresp;
      e.tmo   = etmo;
      sb.push_back(e);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge ACLK);
      if (cmd_ready === 1'b1) ok = 1'b1;
      @(posedge ACLK);
    end
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
    if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge ACLK);
    if (sb.size() != 0) chk("rsp_drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int unsigned acc, prev, aw0, w0;
    bit seen;
    ARESET = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_ctrl", 32'({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready, rsp_timeout}), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_resp", 32'(rsp_resp), 32'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    @(posedge ACLK); #1 rsp_ready = 1'b1;

    // Four writes back to back; zero-wait slave gives a 4-edge spacing.
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'(4 * i), 32'(i + 1), 4'hF, 1'b1, 32'h0, RESP_OKAY, 1'b0, acc);
      if (i > 0) chk("wr_spacing", acc - prev, 32'd4);
      prev = acc;
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b1, 32'(i + 1), RESP_OKAY, 1'b0, acc);
      if (i > 0) chk("rd_spacing", acc - prev, 32'd4);
      prev = acc;
    end
    drain();

    // AW ready early / W late, then the reverse.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    aw_dly = 0; w_dly = 3;
    send(1'b1, 32'h8, 32'h55, 4'hF, 1'b1, 32'h0, RESP_OKAY, 1'b0, acc);
    drain();
    chk("aw_once_wlate", aw_hs_cnt - aw0, 32'd1);
    chk("w_once_wlate", w_hs_cnt - w0, 32'd1);
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    aw_dly = 3; w_dly = 0;
    send(1'b1, 32'h8, 32'h66, 4'hF, 1'b1, 32'h0, RESP_OKAY, 1'b0, acc);
    drain();
    chk("aw_once_awlate", aw_hs_cnt - aw0, 32'd1);
    chk("w_once_awlate", w_hs_cnt - w0, 32'd1);
    aw_dly = 0;
    send(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h66, RESP_OKAY, 1'b0, acc);
    drain();

    // Response back-pressure for 5 cycles.
    rsp_ready = 1'b0;
    send(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h2, RESP_OKAY, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge ACLK);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("rsp_valid_wait_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'h2);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge ACLK);
    end
    @(posedge ACLK); #1 rsp_ready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("idle_after_rsp", 32'({cmd_ready, rsp_valid}), 32'b10);
    @(posedge ACLK); #1;

    // Partial-strobe write.
    send(1'b1, 32'h4, 32'h11223344, 4'hF, 1'b1, 32'h0, RESP_OKAY, 1'b0, acc);
    send(1'b1, 32'h4, 32'hAABBCCDD, 4'b0011, 1'b1, 32'h0, RESP_OKAY, 1'b0, acc);
    send(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h1122CCDD, RESP_OKAY, 1'b0, acc);

    // Error responses pass through unchanged.
    send(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, RESP_DECERR, 1'b0, acc);
    send(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, RESP_DECERR, 1'b0, acc);
    drain();

    // Reset while waiting for R; the abandoned read produces no response.
    r_dly = 10;
    send(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, RESP_OKAY, 1'b0, acc);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("in_rd_resp_rready", 32'(m_axi_rready), 32'd1);
    @(posedge ACLK); #1 ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("midreset_ctrl", 32'({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                              m_axi_arvalid, m_axi_rready, rsp_timeout}), 32'd0);
    chk("midreset_rdata", rsp_rdata, 32'd0);
    chk("midreset_resp", 32'(rsp_resp), 32'd0);
    @(posedge ACLK); #1 ARESET = 1'b0; r_dly = 0;
    send(1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 32'h4, RESP_OKAY, 1'b0, acc);
    drain();

`ifdef REG64_AXIL_TIMEOUT_EN
    // Read that never gets arready: accepted at edge N, rsp_valid appears
    // after edge N+TMO, i.e. in cycle N+TMO+1.
    ar_block = 1'b1;
    send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, RESP_SLVERR, 1'b1, acc);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge ACLK);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("tmo_wait_timeout", 32'd0, 32'd1);
    chk("tmo_latency", cyc - acc, 32'(TMO));
    chk("tmo_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("tmo_flag", 32'(rsp_timeout), 32'd1);
    drain();
    ar_block = 1'b0;
    send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1, RESP_OKAY, 1'b0, acc);
    drain();
`endif

    repeat (2) @(posedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d responses pending", sb.size());
    $fatal(1, "bench time limit");
  end

endmodule
